// File: rtl/seq_mul_ctrl_if.sv
// rtl/seq_mul_ctrl_if.sv - start/abort/busy/done handshake between requester and multiplier control
interface seq_mul_ctrl_if;
  logic start;
  logic abort;
  logic busy;
  logic done;

  modport master (
    output start,
    output abort,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  abort,
    output busy,
    output done
  );
endinterface

// File: rtl/seq_mul_ctrl.sv
// rtl/seq_mul_ctrl.sv - control FSM sequencing the shift-add multiplier datapath and iteration counter
module seq_mul_ctrl #(
  parameter int ITER = 4,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            reset,
  seq_mul_ctrl_if.slave   hs,
  input  logic            q0,
  input  logic            cnt_tc,
  output logic            load_regs,
  output logic            add_en,
  output logic            shift_en,
  output logic            cnt_load,
  output logic            cnt_en,
  output logic [CW-1:0]   cnt_data,
  output logic [CW-1:0]   cnt_lmt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TEST  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CW-1:0] LIMIT = CW'(ITER - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;

  always_comb begin
    state_nxt = state;
    // abort outranks every other exit from a busy state
    if (state != S_IDLE && hs.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (hs.start) state_nxt = S_LOAD;
        S_LOAD:  state_nxt = S_TEST;
        S_TEST:  state_nxt = q0 ? S_ADD : S_SHIFT;
        S_ADD:   state_nxt = S_SHIFT;
        S_SHIFT: state_nxt = cnt_tc ? S_DONE : S_TEST;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Moore decode; strobes fall with the state register when reset asserts
  assign load_regs = (state == S_LOAD);
  assign cnt_load  = (state == S_LOAD);
  assign add_en    = (state == S_ADD);
  assign shift_en  = (state == S_SHIFT);
  assign cnt_en    = (state == S_SHIFT);
  assign hs.done   = (state == S_DONE);
  assign hs.busy   = (state != S_IDLE);
  assign cnt_data  = '0;
  assign cnt_lmt   = LIMIT;

endmodule

// File: doc/seq_mul_ctrl.md
Name: seq_mul_ctrl

Overview:
Control FSM for the shift-add sequential multiplier. It sequences the multiplicand/multiplier/accumulator datapath and drives the loadable iteration counter through its load/enable/limit interface. It uses the counter's registered terminal-count flag to end the multiply. It sits between the top-level start/done handshake and the datapath strobes.

Parameters:
ITER, 4, number of multiplier bits, which is also the number of shift-add iterations; legal range 1 to 2^CW.
CW, 2, iteration-counter width in bits.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset; 0 forces IDLE immediately.
start  input  1  request a multiply; sampled only in IDLE.
abort  input  1  synchronous cancel; honoured in any state except IDLE.
q0  input  1  LSB of the datapath multiplier shift register.
cnt_tc  input  1  counter terminal count (registered: high in the cycle after counter value == cnt_lmt).
load_regs  output  1  load multiplicand/multiplier, clear accumulator.
add_en  output  1  accumulator <= accumulator + multiplicand.
shift_en  output  1  shift the accumulator:multiplier pair right by one.
cnt_load  output  1  counter load strobe.
cnt_en  output  1  counter increment enable.
cnt_data  output  CW  counter load value; constant 0.
cnt_lmt  output  CW  counter limit; constant ITER-1.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse; product valid in datapath.

Behaviour:
- States: IDLE, LOAD, TEST, ADD, SHIFT, DONE. Binary encoding in a single state register.
- All outputs are Moore outputs decoded from the state register.
- Reset (reset=0, asynchronous, any state): state becomes IDLE and every output is 0, except cnt_data=0 and cnt_lmt=ITER-1 (constants).
- IDLE: all strobes 0. start=1 moves to LOAD; otherwise stay.
- LOAD (1 cycle): load_regs=1, cnt_load=1. Next state TEST.
- TEST (1 cycle): q0=1 goes to ADD; q0=0 goes to SHIFT. q0 is sampled only here.
- ADD (1 cycle): add_en=1. Next state SHIFT.
- SHIFT (1 cycle): shift_en=1, cnt_en=1.
  - cnt_tc=1 goes to DONE; otherwise go to TEST.
  - The counter value is stable for at least one cycle before SHIFT, so in SHIFT of iteration i (0-based), cnt_tc equals (i == ITER-1).
- DONE (1 cycle): done=1. Next state IDLE.
- Counter wrap after the last increment (ITER-1 to ITER, mod 2^CW) is harmless; it is reloaded in the next LOAD.
- Latency: with start sampled at edge 0, LOAD occupies cycle 1. Each iteration takes 2 cycles (q0=0) or 3 cycles (q0=1). DONE occupies cycle 2 + 2*ITER + popcount(multiplier).
- start while busy (including the DONE cycle) is ignored, not queued.
- abort=1 in LOAD, TEST, ADD, SHIFT or DONE:
  - next state is IDLE, and done is not asserted afterwards;
  - the strobes of the current cycle still issue, because they are Moore outputs;
  - abort has priority over every other transition.
- abort in IDLE has no effect. abort and start together in IDLE: start wins, go to LOAD.
- Reset mid-operation: immediate IDLE, no done. The next start runs a full fresh sequence.
- At most one of load_regs/add_en/shift_en is high in any cycle. cnt_load and cnt_en are never high together.

Test Plan:
- ITER=4, multiplier 4'b0000, multiplicand 4'd9, start pulse at edge 0 -> state trace LOAD, (TEST,SHIFT)x4, DONE. done=1 only in cycle 10, add_en never high, product 0.
- Multiplier 4'b1111, multiplicand 4'd15 -> 4 add_en pulses, 4 shift_en pulses. done in cycle 14, product 8'd225. cnt_tc is high exactly in the 4th SHIFT.
- Multiplier 4'b0101, multiplicand 4'd7 -> add_en only in iterations 0 and 2. done in cycle 12, product 8'd35.
- start held high for the whole 14-cycle run of 4'b1111 -> exactly one done pulse. Re-entry to LOAD occurs one cycle after done (start seen in IDLE); no second LOAD is issued during busy.
- reset driven low in cycle 5 (mid ADD) -> busy and all strobes 0 asynchronously, no done. After release, start with 4'b0011 x 4'd5 -> product 8'd15, done in cycle 12.
- abort=1 in the 2nd SHIFT -> IDLE next cycle, done never asserted, busy=0. A following start completes normally.
